// File: rtl/stream_mux_nto1.sv
// N-to-1 registered valid/ready stream mux.
// Fixed-select or round-robin grant, one output register stage.
module stream_mux_nto1 #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan
);

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load;
  logic             xfer;

  assign load = !out_valid || out_ready;

  // Search from last+1 downward in priority so the nearest valid wins.
  always_comb begin : grant_sel
    int idx;
    grant_ok = 1'b0;
    grant    = '0;
    idx      = 0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(last) + 1 + k) % N;
        if (in_valid[idx]) begin
          grant_ok = 1'b1;
          grant    = SEL_W'(idx);
        end
      end
    end else if (int'(sel) < N) begin
      grant_ok = 1'b1;
      grant    = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && grant_ok &&
                    (grant == SEL_W'(i));
    end
  end

  assign xfer = load && grant_ok &&
                in_valid[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_chan  <= grant;
      if (mode) begin
        last <= grant;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised N-input, registered stream multiplexer, the next generation of the team's combinational 2:1 mux. Selects one of N valid/ready input channels, by explicit select or by round-robin arbitration, and forwards its data through a single output register stage with full backpressure. It sits between multiple producers and one consumer wherever a shared datapath needs flow control and fair or steered access.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- N, 4: number of input channels, ≥2.
- SEL_W, $clog2(N): width of `sel` and `out_chan`. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select by `sel`; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode = 0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_chan  output  SEL_W  index of the channel that produced out_data.

## Operation
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, round-robin pointer `last` = N-1.
- Load enable: `load = !out_valid || out_ready`. The register accepts a new word only when it is empty or is being drained in the same cycle.
- Grant, mode 0: grant = `sel` when sel < N. When sel ≥ N there is no grant and all in_ready are 0. The grant does not depend on in_valid.
- Grant, mode 1: grant = the first channel with in_valid = 1, searching from (last+1) mod N upward with wrap-around. When no channel is valid there is no grant.
- in_ready[i] = load && (grant == i). This is combinational from out_ready, mode, sel, in_valid and state.
- Input transfer: in_valid[g] && in_ready[g]. On transfer, out_data ← in_data[g], out_chan ← g, out_valid ← 1. In mode 1, last ← g.
- Output transfer: out_valid && out_ready.
- Output transfer with no input transfer: out_valid ← 0. out_data and out_chan hold their values.
- Simultaneous output and input transfer: the register is replaced in the same cycle and out_valid stays 1. This gives full throughput.
- Backpressure: while out_valid = 1 and out_ready = 0, all in_ready are 0 and out_data, out_chan and out_valid are held stable.
- last updates only on an input transfer in mode 1. It never updates in mode 0.
- A mode or sel change affects only the next grant decision. It never alters a word already held.
- Reset asserted mid-operation clears state immediately and asynchronously. Any held word is dropped.

## Timing
- Latency: an input transfer at edge k gives out_valid = 1 with that data after edge k, i.e. in cycle k+1.
- Throughput: one word per cycle when out_ready is held at 1.
- There is no combinational path from any in_data to out_data.
- in_ready has a combinational path from out_ready. The upstream side must not make in_valid depend on in_ready.
- Round-robin fairness: with all N channels continuously valid and out_ready = 1, each channel is granted exactly once in every N consecutive transfers.
- Reset release is synchronous to clk at the design level. The first grant is possible in the first cycle after deassertion, and in mode 1 it starts at channel 0.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with out_valid = 1 → out_valid = 0, out_data = 0, out_chan = 0 immediately; in_ready = 0 only while no grant exists.
- Fixed select, N = 4, WIDTH = 8: mode = 0, sel = 2, in_data ch2 = 0xA5, in_valid = 4'b0100, out_ready = 1 → in_ready = 4'b0100; next cycle out_data = 0xA5, out_chan = 2, out_valid = 1.
- Backpressure: hold out_ready = 0 for 5 cycles with a word held → in_ready = 0 throughout and out_data/out_chan unchanged; the word drains on the cycle out_ready = 1.
- Round-robin: mode = 1, all in_valid = 1, ch i data = 0x10+i, out_ready = 1 → out_chan sequence 0,1,2,3,0,1 and out_data 0x10,0x11,0x12,0x13,0x10,0x11, one per cycle.
- Round-robin skip: mode = 1, last = 0, in_valid = 4'b1001 → grant 3, then 0, then 3.
- Out-of-range select: N = 3, mode = 0, sel = 3, in_valid = 3'b111 → in_ready = 0 and out_valid stays 0.
